// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg: shared types and constants for the
// sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam int          BCD_DIGITS = 7;
  localparam int          BCD_BITS   = 4 * BCD_DIGITS;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam logic [3:0]  BCD_NINE   = 4'd9;
  localparam logic [23:0] BCD_MAX    = 24'd9_999_999;

  // Replace leading zero digits (from the top down) with
  // the display blank code; the units digit always shows.
  function automatic logic [BCD_BITS-1:0] bcd_blank_lead(
    input logic [BCD_BITS-1:0] v
  );
    logic [BCD_BITS-1:0] r;
    logic                lead;
    r    = v;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_adj.sv
// bcd_digit_adj: shift-and-add-3 digit correction.
// Ports: d (BCD digit), q (d + 3 when d >= 5, else d).
import bin_to_bcd_pkg::*;

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: serial binary-to-BCD, one bit per clock.
// Ports: clock, reset (async high), start, bin -> busy,
//   done pulse, ovf, mod0..mod6 (mod0 = units).
// Option: BIN_TO_BCD_BLANK_EN blanks leading zero digits.
import bin_to_bcd_pkg::*;

module bin_to_bcd #(
  parameter int WIDTH = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       mod0,
  output logic [3:0]       mod1,
  output logic [3:0]       mod2,
  output logic [3:0]       mod3,
  output logic [3:0]       mod4,
  output logic [3:0]       mod5,
  output logic [3:0]       mod6
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]    bin_reg;
  logic [BCD_BITS-1:0] acc;
  logic [BCD_BITS-1:0] acc_adj;
  logic [CW-1:0]       cnt;
  logic                ovf_pend;
  logic [BCD_BITS-1:0] mods;

  logic                accept;
  logic                shift_en;
  logic                load_en;
  logic [BCD_BITS-1:0] result;
  logic [24:0]         bin_ext;

  // Extra bit keeps the compare legal for any WIDTH;
  // narrower inputs can never exceed BCD_MAX.
  assign bin_ext = 25'(bin);

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc[g*4 +: 4]),
      .q (acc_adj[g*4 +: 4])
    );
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (cnt == CNT_ONE) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    load_en  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      LOAD: begin
        busy    = 1'b1;
        load_en = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Saturation wins over blanking.
  always_comb begin
    if (ovf_pend) begin
      result = {BCD_DIGITS{BCD_NINE}};
    end else begin
`ifdef BIN_TO_BCD_BLANK_EN
      result = bcd_blank_lead(acc);
`else
      result = acc;
`endif
    end
  end

  // Conversion datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_reg  <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      bin_reg  <= bin;
      acc      <= '0;
      cnt      <= CNT_INIT;
      ovf_pend <= (bin_ext > {1'b0, BCD_MAX});
    end else if (shift_en) begin
      // Top carry of acc_adj only occurs on overflow,
      // where the saturated result replaces it anyway.
      acc     <= {acc_adj[BCD_BITS-2:0], bin_reg[WIDTH-1]};
      bin_reg <= bin_reg << 1;
      cnt     <= cnt - CNT_ONE;
    end
  end

  // Registered outputs; change only at LOAD or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mods <= {BCD_DIGITS{BCD_BLANK}};
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= load_en;
      if (load_en) begin
        mods <= result;
        ovf  <= ovf_pend;
      end
    end
  end

  assign mod0 = mods[3:0];
  assign mod1 = mods[7:4];
  assign mod2 = mods[11:8];
  assign mod3 = mods[15:12];
  assign mod4 = mods[19:16];
  assign mod5 = mods[23:20];
  assign mod6 = mods[27:24];

endmodule
